cache_profiler_mc: RTL and testbench
====================================

CACHE_PROFILER_MC -- requirements
Module: cache_profiler_mc

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, meaning number of monitored cache channels (1..8).
REQ-002 SHALL provide parameter CNT_W, default 32, meaning width of every counter (8..64).
REQ-003 SHALL provide parameter SATURATE, default 1, meaning 1 = counters stick at all-ones, 0 = counters wrap to 0.
REQ-004 SHALL provide port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port enable  input  1  count enable; when low, live counters hold.
REQ-007 SHALL provide port clear  input  1  synchronous clear of live counters and overflow flags.
REQ-008 SHALL provide port snapshot  input  1  copy live counters into the output shadow registers.
REQ-009 SHALL provide port request  input  NUM_CH  per-channel cache request level.
REQ-010 SHALL provide port hit  input  NUM_CH  per-channel cache hit level.
REQ-011 SHALL provide port fill_busy  input  NUM_CH  per-channel line-fill-in-progress level.
REQ-012 SHALL provide ports req_cnt, hit_cnt, miss_cnt, fill_cyc_cnt, fill_max  output  NUM_CH*CNT_W each  shadow values; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 SHALL provide port overflow  output  NUM_CH  live sticky per-channel overflow flag.
REQ-014 SHALL provide port snap_valid  output  1  high once at least one snapshot has been taken since the last rst or clear.

Function
REQ-015 SHALL register the previous level of request, hit and fill_busy every cycle, regardless of enable; reset value 0.
REQ-016 SHALL increment the live req count of channel i on a cycle where enable=1, request[i]=1 and the previous request[i]=0; a held-high level counts once.
REQ-017 SHALL increment the live hit count under the same rising-edge rule applied to hit[i].
REQ-018 SHALL increment the live fill-cycle count on every cycle where enable=1 and fill_busy[i]=1.
REQ-019 SHALL keep a per-channel run counter: +1 on each enabled cycle with fill_busy[i]=1; 0 on any cycle with fill_busy[i]=0; hold when enable=0 and fill_busy[i]=1.
REQ-020 SHALL update the live fill max to max(current max, run+1) on each increment cycle, so that an in-progress fill is reflected immediately.
REQ-021 SHALL compute the miss value as req - hit when req >= hit, and as 0 otherwise, CNT_W bits wide, using the values captured in the shadow registers.
REQ-022 SHALL, with SATURATE=1, hold any counter that is at all-ones on further increments; with SATURATE=0, wrap that counter to 0.
REQ-023 SHALL set overflow[i] on any increment attempt of a channel-i counter (req, hit, fill-cycle or run) that is at all-ones, in either mode; the flag stays set until rst or clear.
REQ-024 SHALL, on snapshot=1, load the shadow registers with the live values as they stand before that edge's updates; outputs change one cycle after the snapshot cycle.
REQ-025 SHALL give a latency, from an input rising edge sampled at edge N, of: live count at N+1; visible on outputs after a snapshot at edge N+1 or later.
REQ-026 SHALL, on clear=1, zero all live counters, run counters and overflow flags, and deassert snap_valid; shadow registers hold unless snapshot is also asserted.
REQ-027 SHALL, when clear and snapshot are asserted together, capture the pre-clear live values into the shadows, set snap_valid=1, and zero the live state (atomic read-and-clear).
REQ-028 SHALL give clear priority over a same-cycle increment; that event is lost.
REQ-029 SHALL operate all channels independently; simultaneous events on different channels are all counted.

Reset
REQ-030 SHALL, while rst=1, zero every live counter, run counter, shadow register, previous-level register, overflow and snap_valid, taking priority over clear, snapshot and enable.
REQ-031 SHALL count, after reset, an input that is already high at the first enabled cycle once, because its previous level resets to 0.

Verification
REQ-032 Scenario: NUM_CH=2; ch0 request pulses 5x, hit 3x, one pulse held for 4 cycles; then snapshot -> req=5, hit=3, miss=2; ch1 all 0.
REQ-033 Scenario: fill_busy[1] high for 3 cycles, then low, then high for 7 cycles; then snapshot -> fill_cyc_cnt=10, fill_max=7.
REQ-034 Scenario: CNT_W=8, SATURATE=1, 300 request edges -> req=255, overflow[0]=1; with SATURATE=0 -> req=44, overflow[0]=1.
REQ-035 Scenario: req=4; assert clear and snapshot in the same cycle -> outputs show 4, live state 0; next snapshot -> 0.
REQ-036 Scenario: enable=0 while request rises and stays high, then enable=1 -> no count; rst asserted mid-fill -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cache_profiler_mc.sv
// Multi-channel cache event profiler.
// Live request/hit/fill counters with snapshot shadow registers.
module cache_profiler_mc #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    snapshot,
  input  logic [NUM_CH-1:0]       request,
  input  logic [NUM_CH-1:0]       hit,
  input  logic [NUM_CH-1:0]       fill_busy,
  output logic [NUM_CH*CNT_W-1:0] req_cnt,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt,
  output logic [NUM_CH*CNT_W-1:0] miss_cnt,
  output logic [NUM_CH*CNT_W-1:0] fill_cyc_cnt,
  output logic [NUM_CH*CNT_W-1:0] fill_max,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    snap_valid
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic [NUM_CH-1:0] req_q, hit_q, fill_q;
  logic [NUM_CH-1:0] req_inc, hit_inc, fill_inc;
  logic [NUM_CH-1:0] ovf_q, ovf_n;
  logic              sv_q;

  logic [CNT_W-1:0] req_l [NUM_CH];
  logic [CNT_W-1:0] hit_l [NUM_CH];
  logic [CNT_W-1:0] fcy_l [NUM_CH];
  logic [CNT_W-1:0] run_l [NUM_CH];
  logic [CNT_W-1:0] max_l [NUM_CH];

  logic [CNT_W-1:0] req_n [NUM_CH];
  logic [CNT_W-1:0] hit_n [NUM_CH];
  logic [CNT_W-1:0] fcy_n [NUM_CH];
  logic [CNT_W-1:0] run_n [NUM_CH];
  logic [CNT_W-1:0] max_n [NUM_CH];

  logic [CNT_W-1:0] req_s [NUM_CH];
  logic [CNT_W-1:0] hit_s [NUM_CH];
  logic [CNT_W-1:0] fcy_s [NUM_CH];
  logic [CNT_W-1:0] max_s [NUM_CH];

  // Increment with either stick-at-all-ones or wrap behaviour.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (v == ONES) return (SATURATE != 0) ? v : '0;
    return v + 1'b1;
  endfunction

  assign req_inc  = {NUM_CH{enable}} & request & ~req_q;
  assign hit_inc  = {NUM_CH{enable}} & hit & ~hit_q;
  assign fill_inc = {NUM_CH{enable}} & fill_busy;

  // Next live values for every channel, before clear is applied.
  always_comb begin
    ovf_n = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      req_n[i] = req_inc[i] ? bump(req_l[i]) : req_l[i];
      hit_n[i] = hit_inc[i] ? bump(hit_l[i]) : hit_l[i];
      fcy_n[i] = fill_inc[i] ? bump(fcy_l[i]) : fcy_l[i];
      if (!fill_busy[i])
        run_n[i] = '0;
      else if (fill_inc[i])
        run_n[i] = bump(run_l[i]);
      else
        run_n[i] = run_l[i];
      max_n[i] = max_l[i];
      if (fill_inc[i] && run_n[i] > max_l[i])
        max_n[i] = run_n[i];
      if ((req_inc[i]  && req_l[i] == ONES) ||
          (hit_inc[i]  && hit_l[i] == ONES) ||
          (fill_inc[i] && fcy_l[i] == ONES) ||
          (fill_inc[i] && run_l[i] == ONES))
        ovf_n[i] = 1'b1;
    end
  end

  // Edge history, live counters, shadows and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      hit_q  <= '0;
      fill_q <= '0;
      ovf_q  <= '0;
      sv_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        req_l[i] <= '0;
        hit_l[i] <= '0;
        fcy_l[i] <= '0;
        run_l[i] <= '0;
        max_l[i] <= '0;
        req_s[i] <= '0;
        hit_s[i] <= '0;
        fcy_s[i] <= '0;
        max_s[i] <= '0;
      end
    end else begin
      req_q  <= request;
      hit_q  <= hit;
      fill_q <= fill_busy;
      if (snapshot) begin
        for (int i = 0; i < NUM_CH; i++) begin
          req_s[i] <= req_l[i];
          hit_s[i] <= hit_l[i];
          fcy_s[i] <= fcy_l[i];
          max_s[i] <= max_l[i];
        end
      end
      if (clear) begin
        ovf_q <= '0;
        sv_q  <= snapshot;
        for (int i = 0; i < NUM_CH; i++) begin
          req_l[i] <= '0;
          hit_l[i] <= '0;
          fcy_l[i] <= '0;
          run_l[i] <= '0;
          max_l[i] <= '0;
        end
      end else begin
        ovf_q <= ovf_n;
        sv_q  <= sv_q | snapshot;
        for (int i = 0; i < NUM_CH; i++) begin
          req_l[i] <= req_n[i];
          hit_l[i] <= hit_n[i];
          fcy_l[i] <= fcy_n[i];
          run_l[i] <= run_n[i];
          max_l[i] <= max_n[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign req_cnt[g*CNT_W +: CNT_W]      = req_s[g];
    assign hit_cnt[g*CNT_W +: CNT_W]      = hit_s[g];
    assign fill_cyc_cnt[g*CNT_W +: CNT_W] = fcy_s[g];
    assign fill_max[g*CNT_W +: CNT_W]     = max_s[g];
    assign miss_cnt[g*CNT_W +: CNT_W]     =
      (req_s[g] >= hit_s[g]) ? req_s[g] - hit_s[g] : '0;
  end

  assign overflow   = ovf_q;
  assign snap_valid = sv_q;

endmodule

// File: tb/tb_cache_profiler_mc.sv
// Testbench for cache_profiler_mc.
// Default instance plus 8-bit saturating and wrapping instances.
module tb_cache_profiler_mc;

  logic       clk = 1'b0;
  logic       rst, enable, clear, snapshot;
  logic [1:0] request, hit, fill_busy;

  logic [63:0] m_req, m_hit, m_miss, m_fcy, m_max;
  logic [1:0]  m_ovf;
  logic        m_sv;
  logic [15:0] s_req, s_hit, s_miss, s_fcy, s_max;
  logic [1:0]  s_ovf;
  logic        s_sv;
  logic [15:0] w_req, w_hit, w_miss, w_fcy, w_max;
  logic [1:0]  w_ovf;
  logic        w_sv;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    int          dut;
    int          fld;
    int          ch;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  cache_profiler_mc u_main (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .snapshot(snapshot), .request(request), .hit(hit),
    .fill_busy(fill_busy), .req_cnt(m_req), .hit_cnt(m_hit),
    .miss_cnt(m_miss), .fill_cyc_cnt(m_fcy), .fill_max(m_max),
    .overflow(m_ovf), .snap_valid(m_sv)
  );

  cache_profiler_mc #(.NUM_CH(2), .CNT_W(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .snapshot(snapshot), .request(request), .hit(hit),
    .fill_busy(fill_busy), .req_cnt(s_req), .hit_cnt(s_hit),
    .miss_cnt(s_miss), .fill_cyc_cnt(s_fcy), .fill_max(s_max),
    .overflow(s_ovf), .snap_valid(s_sv)
  );

  cache_profiler_mc #(.NUM_CH(2), .CNT_W(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .snapshot(snapshot), .request(request), .hit(hit),
    .fill_busy(fill_busy), .req_cnt(w_req), .hit_cnt(w_hit),
    .miss_cnt(w_miss), .fill_cyc_cnt(w_fcy), .fill_max(w_max),
    .overflow(w_ovf), .snap_valid(w_sv)
  );

  // fld: 0 req 1 hit 2 miss 3 fill_cyc 4 fill_max 5 overflow 6 snap_valid
  function automatic logic [63:0] peek(int dut, int fld, int ch);
    logic [63:0] v;
    v = '0;
    if (dut == 0) begin
      case (fld)
        0: v = 64'(m_req[ch*32 +: 32]);
        1: v = 64'(m_hit[ch*32 +: 32]);
        2: v = 64'(m_miss[ch*32 +: 32]);
        3: v = 64'(m_fcy[ch*32 +: 32]);
        4: v = 64'(m_max[ch*32 +: 32]);
        5: v = 64'(m_ovf[ch]);
        default: v = 64'(m_sv);
      endcase
    end else if (dut == 1) begin
      case (fld)
        0: v = 64'(s_req[ch*8 +: 8]);
        1: v = 64'(s_hit[ch*8 +: 8]);
        2: v = 64'(s_miss[ch*8 +: 8]);
        3: v = 64'(s_fcy[ch*8 +: 8]);
        4: v = 64'(s_max[ch*8 +: 8]);
        5: v = 64'(s_ovf[ch]);
        default: v = 64'(s_sv);
      endcase
    end else begin
      case (fld)
        0: v = 64'(w_req[ch*8 +: 8]);
        1: v = 64'(w_hit[ch*8 +: 8]);
        2: v = 64'(w_miss[ch*8 +: 8]);
        3: v = 64'(w_fcy[ch*8 +: 8]);
        4: v = 64'(w_max[ch*8 +: 8]);
        5: v = 64'(w_ovf[ch]);
        default: v = 64'(w_sv);
      endcase
    end
    return v;
  endfunction

  task automatic push(input string n, input int d, input int f,
                      input int c, input logic [63:0] e);
    sb_t x;
    x.name = n; x.dut = d; x.fld = f; x.ch = c; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] rq, input logic [1:0] ht,
                       input int len);
    request = rq;
    hit     = ht;
    repeat (len) tick();
    request = '0;
    hit     = '0;
    tick();
  endtask

  task automatic snap();
    snapshot = 1'b1;
    tick();
    snapshot = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0; snapshot = 1'b0;
    request = '0; hit = '0; fill_busy = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [63:0] a;
    rst = 1'b1; enable = 1'b1; clear = 1'b1; snapshot = 1'b1;
    request = '1; hit = '1; fill_busy = '1;
    tick(); tick();
    checks++;
    if ({m_req, m_hit, m_fcy, m_max, m_ovf, m_sv} !== '0) begin
      fails++;
      $display("FAIL reset_main: outputs not zero under rst");
    end
    checks++;
    if ({s_req, s_fcy, s_ovf, s_sv, w_req, w_fcy, w_ovf, w_sv} !== '0) begin
      fails++;
      $display("FAIL reset_8bit: outputs not zero under rst");
    end
    clear = 1'b0; snapshot = 1'b0; fill_busy = '0;
    rst = 1'b0;
    repeat (3) tick();
    request = '0; hit = '0;
    tick();
    push("rst_req0", 0, 0, 0, 1);
    push("rst_hit0", 0, 1, 0, 1);
    push("rst_miss0", 0, 2, 0, 0);
    push("rst_req1", 0, 0, 1, 1);
    push("rst_sv", 0, 6, 0, 1);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
  endtask

  task automatic test_req_hit();
    sb_t e;
    logic [63:0] a;
    do_reset();
    pulse(2'b01, 2'b01, 1);
    pulse(2'b01, 2'b01, 1);
    pulse(2'b01, 2'b00, 1);
    pulse(2'b01, 2'b01, 4);
    pulse(2'b01, 2'b00, 1);
    push("rh_req0", 0, 0, 0, 5);
    push("rh_hit0", 0, 1, 0, 3);
    push("rh_miss0", 0, 2, 0, 2);
    push("rh_req1", 0, 0, 1, 0);
    push("rh_hit1", 0, 1, 1, 0);
    push("rh_miss1", 0, 2, 1, 0);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
  endtask

  task automatic test_channels();
    sb_t e;
    logic [63:0] a;
    do_reset();
    pulse(2'b11, 2'b10, 1);
    pulse(2'b01, 2'b10, 2);
    pulse(2'b00, 2'b10, 1);
    push("ch_req0", 0, 0, 0, 2);
    push("ch_miss0", 0, 2, 0, 2);
    push("ch_req1", 0, 0, 1, 1);
    push("ch_hit1", 0, 1, 1, 3);
    push("ch_miss1_clamp", 0, 2, 1, 0);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
  endtask

  task automatic test_fill();
    sb_t e;
    logic [63:0] a;
    do_reset();
    fill_busy = 2'b10;
    repeat (3) tick();
    fill_busy = 2'b00;
    tick();
    fill_busy = 2'b10;
    repeat (7) tick();
    fill_busy = 2'b00;
    tick();
    push("fill_cyc1", 0, 3, 1, 10);
    push("fill_max1", 0, 4, 1, 7);
    push("fill_cyc0", 0, 3, 0, 0);
    push("fill_max1_8b", 1, 4, 1, 7);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
  endtask

  task automatic test_saturate();
    sb_t e;
    logic [63:0] a;
    do_reset();
    repeat (300) pulse(2'b01, 2'b00, 1);
    push("sat_req0", 1, 0, 0, 255);
    push("sat_ovf0", 1, 5, 0, 1);
    push("sat_ovf1", 1, 5, 1, 0);
    push("wrap_req0", 2, 0, 0, 44);
    push("wrap_ovf0", 2, 5, 0, 1);
    push("wide_req0", 0, 0, 0, 300);
    push("wide_ovf0", 0, 5, 0, 0);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
  endtask

  task automatic test_clear_snap();
    sb_t e;
    logic [63:0] a;
    do_reset();
    repeat (4) pulse(2'b01, 2'b00, 1);
    request = 2'b01;
    clear = 1'b1; snapshot = 1'b1;
    tick();
    clear = 1'b0; snapshot = 1'b0;
    tick();
    request = '0;
    tick();
    push("cs_req0", 0, 0, 0, 4);
    push("cs_sv", 0, 6, 0, 1);
    push("cs_ovf_s", 1, 5, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
    push("cs_after_req0", 0, 0, 0, 0);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (m_sv !== 1'b0) begin
      fails++;
      $display("FAIL clear_sv: got %0d expected 0", m_sv);
    end
  endtask

  task automatic test_enable_rst();
    sb_t e;
    logic [63:0] a;
    do_reset();
    enable = 1'b0;
    request = 2'b01;
    repeat (3) tick();
    enable = 1'b1;
    repeat (3) tick();
    request = '0;
    tick();
    push("en_req0", 0, 0, 0, 0);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
    fill_busy = 2'b01;
    repeat (3) tick();
    push("mid_fcy0", 0, 3, 0, 3);
    push("mid_max0", 0, 4, 0, 3);
    snap();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = peek(e.dut, e.fld, e.ch);
      checks++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({m_req, m_hit, m_miss, m_fcy, m_max, m_ovf, m_sv} !== '0) begin
      fails++;
      $display("FAIL rst_midfill: fcy0 got %0d expected 0, sv %0d",
               m_fcy[31:0], m_sv);
    end
    rst = 1'b0;
    fill_busy = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_req_hit();
    test_channels();
    test_fill();
    test_saturate();
    test_clear_snap();
    test_enable_rst();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
